// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a rectangle command to the screen and streams raster-order pixel writes.
// Optional outline mode is compiled in with `define RECT_OUTLINE_EN.
module rect_fill_engine #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk_100mhz_buf,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [2:0]        cmd_color,
  input  logic              cmd_outline,
  input  logic              fb_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] Waddr,
  output logic [2:0]        Wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;

  localparam logic [10:0]       H_RES11 = 11'(H_RES);
  localparam logic [9:0]        V_RES10 = 10'(V_RES);
  localparam logic [ADDR_W-1:0] H_STEP  = ADDR_W'(H_RES);

  state_t              state_q, state_d;
  logic [9:0]          cx_q, cx_d, cw_q, cw_d;
  logic [8:0]          cy_q, cy_d, ch_q, ch_d;
  logic [2:0]          color_q, color_d;
  logic [10:0]         x_q, x_d, x1_q, x1_d;
  logic [9:0]          y_q, y_d, y1_q, y1_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [2:0]          wdata_q, wdata_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_valid_q, wr_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [10:0]         sum_x, x1_c;
  logic [9:0]          sum_y, y1_c;
  logic                empty_c;
  logic [ADDR_W-1:0]   row0_c;
  logic                accept, last_col, last_row;

`ifdef RECT_OUTLINE_EN
  logic outline_q, outline_d;
`else
  logic unused_outline;
  assign unused_outline = cmd_outline;
`endif

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    cw_d       = cw_q;
    ch_d       = ch_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    row_base_d = row_base_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef RECT_OUTLINE_EN
    outline_d  = outline_q;
`endif

    sum_x    = {1'b0, cx_q} + {1'b0, cw_q};
    x1_c     = (sum_x > H_RES11) ? H_RES11 : sum_x;
    sum_y    = {1'b0, cy_q} + {1'b0, ch_q};
    y1_c     = (sum_y > V_RES10) ? V_RES10 : sum_y;
    empty_c  = (cw_q == 10'd0) || (ch_q == 9'd0) ||
               ({1'b0, cx_q} >= H_RES11) || ({1'b0, cy_q} >= V_RES10);
    // y*640 as y*512 + y*128, keeping multipliers out of the address path
    row0_c   = ADDR_W'({cy_q, 9'b0}) + ADDR_W'({cy_q, 7'b0});
    accept   = wr_valid_q && fb_ready;
    last_col = (x_q == x1_q - 11'd1);
    last_row = (y_q == y1_q - 10'd1);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cx_d    = cmd_x;
          cy_d    = cmd_y;
          cw_d    = cmd_w;
          ch_d    = cmd_h;
          color_d = cmd_color;
`ifdef RECT_OUTLINE_EN
          outline_d = cmd_outline;
`endif
          state_d = CLIP;
        end
      end
      CLIP: begin
        wdata_d = color_q;
        x1_d    = x1_c;
        y1_d    = y1_c;
        if (empty_c) begin
          state_d = DONE;
        end else begin
          row_base_d = row0_c;
          x_d        = {1'b0, cx_q};
          y_d        = {1'b0, cy_q};
          waddr_d    = row0_c + ADDR_W'(cx_q);
          state_d    = DRAW;
        end
      end
      DRAW: begin
        if (accept) begin
          if (last_col) begin
            if (last_row) begin
              state_d = DONE;
            end else begin
              row_base_d = row_base_q + H_STEP;
              x_d        = {1'b0, cx_q};
              y_d        = y_q + 10'd1;
              waddr_d    = row_base_q + H_STEP + ADDR_W'(cx_q);
            end
`ifdef RECT_OUTLINE_EN
          end else if (outline_q && (y_q != {1'b0, cy_q}) && !last_row &&
                       (x_q == {1'b0, cx_q})) begin
            // interior row of an outline: skip straight to the right border
            x_d     = x1_q - 11'd1;
            waddr_d = row_base_q + ADDR_W'(x1_q) - ADDR_W'(1);
`endif
          end else begin
            x_d     = x_q + 11'd1;
            waddr_d = waddr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    wr_valid_d  = (state_d == DRAW);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk_100mhz_buf or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      cw_q        <= '0;
      ch_q        <= '0;
      color_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      row_base_q  <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RECT_OUTLINE_EN
      outline_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      cw_q        <= cw_d;
      ch_q        <= ch_d;
      color_q     <= color_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      row_base_q  <= row_base_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      wr_valid_q  <= wr_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef RECT_OUTLINE_EN
      outline_q   <= outline_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_valid  = wr_valid_q;
  assign Waddr     = waddr_q;
  assign Wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: fills, clipping, stalls, empty commands, reset mid-command, outline.
// Cycle 1 is the CLIP cycle right after the acceptance edge; a fill of N pixels reports done in cycle N+2.
module tb_rect_fill_engine;

  logic        clk_100mhz_buf = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0;
  logic [8:0]  cmd_y = '0;
  logic [9:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [2:0]  cmd_color = '0;
  logic        cmd_outline = 1'b0;
  logic        fb_ready = 1'b1;
  logic        wr_valid;
  logic [18:0] Waddr;
  logic [2:0]  Wdata;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  int   got_addr[$];
  int   got_data[$];
  bit   fb_pat[$];
  int   done_cyc;
  int   first_wr;
  int   stall_bad;
  logic rdy_at_issue;

  rect_fill_engine #(.H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
    .clk_100mhz_buf(clk_100mhz_buf),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .cmd_outline(cmd_outline),
    .fb_ready(fb_ready),
    .wr_valid(wr_valid),
    .Waddr(Waddr),
    .Wdata(Wdata),
    .busy(busy),
    .done(done)
  );

  always #5 clk_100mhz_buf = ~clk_100mhz_buf;

  task automatic tick();
    @(posedge clk_100mhz_buf);
    #1;
  endtask

  // Issues one command and records every accepted write until done (or the budget runs out).
  task automatic run_cmd(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                         input logic [8:0] h, input logic [2:0] c, input logic ol, input int budget);
    logic        pv;
    logic [18:0] pa;
    logic [2:0]  pd;
    got_addr.delete();
    got_data.delete();
    done_cyc     = -1;
    first_wr     = -1;
    stall_bad    = 0;
    rdy_at_issue = cmd_ready;
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c; cmd_outline = ol;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_x = '1; cmd_y = '1; cmd_w = '1; cmd_h = '1; cmd_color = '0; cmd_outline = 1'b0;
    pv = 1'b0; pa = '0; pd = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      fb_ready = 1'b1;
      if (wr_valid && fb_pat.size() > 0) fb_ready = fb_pat.pop_front();
      #1;
      if (pv && (Waddr !== pa || Wdata !== pd)) stall_bad++;
      if (wr_valid && first_wr < 0) first_wr = cyc;
      if (wr_valid && fb_ready) begin
        got_addr.push_back(int'(Waddr));
        got_data.push_back(int'(Wdata));
      end
      pv = wr_valid && !fb_ready; pa = Waddr; pd = Wdata;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    fb_ready = 1'b1;
    fb_pat.delete();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_vec++;
    if (cmd_ready !== 1'b1 || wr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
        Waddr !== 19'd0 || Wdata !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b wv=%b done=%b busy=%b addr=%0d data=%0d, want 1 0 0 0 0 0",
               cmd_ready, wr_valid, done, busy, Waddr, Wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_2x2();
    int exp_a[4] = '{0, 1, 640, 641};
    run_cmd(10'd0, 9'd0, 10'd2, 9'd2, 3'd3, 1'b0, 50);
    n_vec++;
    if (rdy_at_issue !== 1'b1) begin
      n_err++; $display("FAIL fill_ready: got %b want 1", rdy_at_issue);
    end
    n_vec++;
    if (got_addr.size() != 4) begin
      n_err++; $display("FAIL fill_count: got %0d want 4", got_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got_addr[i] != exp_a[i] || got_data[i] != 3) begin
          n_err++;
          $display("FAIL fill_write%0d: got addr=%0d data=%0d want addr=%0d data=3",
                   i, got_addr[i], got_data[i], exp_a[i]);
        end
      end
    end
    n_vec++;
    if (first_wr != 2) begin
      n_err++; $display("FAIL fill_first_latency: got %0d want 2", first_wr);
    end
    n_vec++;
    if (done_cyc != 6) begin
      n_err++; $display("FAIL fill_done_latency: got %0d want 6", done_cyc);
    end
  endtask

  task automatic test_clip();
    int bad = 0;
    int mx  = 0;
    run_cmd(10'd630, 9'd470, 10'd20, 9'd20, 3'd5, 1'b0, 200);
    n_vec++;
    if (got_addr.size() != 100) begin
      n_err++; $display("FAIL clip_count: got %0d want 100", got_addr.size());
    end else begin
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++) begin
          if (got_addr[r*10+c] != (470 + r) * 640 + 630 + c) bad++;
          if (got_addr[r*10+c] > mx) mx = got_addr[r*10+c];
        end
      n_vec++;
      if (bad != 0) begin
        n_err++; $display("FAIL clip_addr_seq: got %0d wrong addresses want 0", bad);
      end
      n_vec++;
      if (got_addr[99] != 307199 || mx >= 307200) begin
        n_err++; $display("FAIL clip_last_addr: got last=%0d max=%0d want last=307199 max<307200",
                          got_addr[99], mx);
      end
    end
    n_vec++;
    if (done_cyc != 102) begin
      n_err++; $display("FAIL clip_done_latency: got %0d want 102", done_cyc);
    end
  endtask

  task automatic test_stall();
    int exp_a[4] = '{0, 1, 640, 641};
    fb_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_cmd(10'd0, 9'd0, 10'd2, 9'd2, 3'd6, 1'b0, 50);
    n_vec++;
    if (stall_bad != 0) begin
      n_err++; $display("FAIL stall_hold: got %0d changes during stall want 0", stall_bad);
    end
    n_vec++;
    if (got_addr.size() != 4) begin
      n_err++; $display("FAIL stall_count: got %0d want 4", got_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got_addr[i] != exp_a[i] || got_data[i] != 6) begin
          n_err++;
          $display("FAIL stall_write%0d: got addr=%0d data=%0d want addr=%0d data=6",
                   i, got_addr[i], got_data[i], exp_a[i]);
        end
      end
    end
    n_vec++;
    if (done_cyc != 9) begin
      n_err++; $display("FAIL stall_done_latency: got %0d want 9", done_cyc);
    end
  endtask

  task automatic test_empty();
    run_cmd(10'd4, 9'd4, 10'd0, 9'd3, 3'd1, 1'b0, 20);
    n_vec++;
    if (got_addr.size() != 0 || first_wr != -1 || done_cyc != 2) begin
      n_err++; $display("FAIL empty_w0: got writes=%0d first_wr=%0d done=%0d want 0 -1 2",
                        got_addr.size(), first_wr, done_cyc);
    end
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL empty_w0_ready: got rdy=%b busy=%b want 1 0", cmd_ready, busy);
    end
    run_cmd(10'd700, 9'd4, 10'd8, 9'd3, 3'd1, 1'b0, 20);
    n_vec++;
    if (got_addr.size() != 0 || first_wr != -1 || done_cyc != 2) begin
      n_err++; $display("FAIL empty_x700: got writes=%0d first_wr=%0d done=%0d want 0 -1 2",
                        got_addr.size(), first_wr, done_cyc);
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL empty_x700_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int nw = 0;
    bit hit = 0;
    cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd4; cmd_h = 9'd4; cmd_color = 3'd2; cmd_outline = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (wr_valid && nw == 2) begin
        hit = 1;
        break;
      end
      if (wr_valid && fb_ready) nw++;
      tick();
    end
    n_vec++;
    if (!hit || Waddr !== 19'd2) begin
      n_err++; $display("FAIL rstmid_reach: got hit=%0d addr=%0d want 1 2", hit, Waddr);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1 || wr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
        Waddr !== 19'd0 || Wdata !== 3'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got rdy=%b wv=%b done=%b busy=%b addr=%0d data=%0d, want 1 0 0 0 0 0",
               cmd_ready, wr_valid, done, busy, Waddr, Wdata);
    end
    #2;
    rst = 1'b0;
    tick();
    run_cmd(10'd5, 9'd0, 10'd1, 9'd1, 3'd7, 1'b0, 20);
    n_vec++;
    if (rdy_at_issue !== 1'b1 || got_addr.size() != 1 || done_cyc != 3) begin
      n_err++; $display("FAIL rstmid_next_cmd: got rdy=%b writes=%0d done=%0d want 1 1 3",
                        rdy_at_issue, got_addr.size(), done_cyc);
    end else begin
      n_vec++;
      if (got_addr[0] != 5 || got_data[0] != 7) begin
        n_err++; $display("FAIL rstmid_next_write: got addr=%0d data=%0d want 5 7",
                          got_addr[0], got_data[0]);
      end
    end
  endtask

`ifdef RECT_OUTLINE_EN
  task automatic test_outline();
    int exp_a[12] = '{6410, 6411, 6412, 6413, 7050, 7053, 7690, 7693, 8330, 8331, 8332, 8333};
    run_cmd(10'd10, 9'd10, 10'd4, 9'd4, 3'd4, 1'b1, 50);
    n_vec++;
    if (got_addr.size() != 12) begin
      n_err++; $display("FAIL outline_count: got %0d want 12", got_addr.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_vec++;
        if (got_addr[i] != exp_a[i]) begin
          n_err++; $display("FAIL outline_write%0d: got %0d want %0d", i, got_addr[i], exp_a[i]);
        end
      end
    end
    n_vec++;
    if (done_cyc != 14) begin
      n_err++; $display("FAIL outline_done_latency: got %0d want 14", done_cyc);
    end
  endtask
`else
  task automatic test_outline();
    run_cmd(10'd10, 9'd10, 10'd4, 9'd4, 3'd4, 1'b1, 50);
    n_vec++;
    if (got_addr.size() != 16 || done_cyc != 18) begin
      n_err++; $display("FAIL outline_ignored: got writes=%0d done=%0d want 16 18",
                        got_addr.size(), done_cyc);
    end else begin
      n_vec++;
      if (got_addr[5] != 7051 || got_addr[6] != 7052) begin
        n_err++; $display("FAIL outline_ignored_row: got %0d,%0d want 7051,7052",
                          got_addr[5], got_addr[6]);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    run_cmd(10'd639, 9'd479, 10'd1, 9'd1, 3'd1, 1'b0, 20);
    n_vec++;
    if (got_addr.size() != 1 || got_addr[0] != 307199 || done_cyc != 3) begin
      n_err++; $display("FAIL b2b_first: got writes=%0d done=%0d want 1 3", got_addr.size(), done_cyc);
    end
    run_cmd(10'd1, 9'd1, 10'd3, 9'd1, 3'd2, 1'b0, 20);
    n_vec++;
    if (rdy_at_issue !== 1'b1 || got_addr.size() != 3 || done_cyc != 5) begin
      n_err++; $display("FAIL b2b_second: got rdy=%b writes=%0d done=%0d want 1 3 5",
                        rdy_at_issue, got_addr.size(), done_cyc);
    end else begin
      n_vec++;
      if (got_addr[0] != 641 || got_addr[2] != 643) begin
        n_err++; $display("FAIL b2b_second_addr: got %0d..%0d want 641..643", got_addr[0], got_addr[2]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_2x2();
    test_clip();
    test_stall();
    test_empty();
    test_reset_mid();
    test_outline();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Drawing-command stage directly upstream of the VGA controller's frame-buffer write port. Accepts one rectangle command at a time (origin, size, 3-bit color index) and clips it to the 640x480 screen. Walks the clipped area in raster order, emitting one linear pixel address plus color index per cycle on the controller's Waddr/Wdata port. Write acceptance is paced by the controller's ready signal.

## Interface
Parameters:
- H_RES, 640, visible pixels per line; also the row stride of the linear address
- V_RES, 480, visible lines
- ADDR_W, 19, frame-buffer address width; H_RES*V_RES must be at most 2^ADDR_W

Ports:
- clk_100mhz_buf  in  1  system clock; frame-buffer write domain
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  10  left column
- cmd_y  in  9  top row
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in lines
- cmd_color  in  3  color index (0 BLACK … 7 GWHITE)
- cmd_outline  in  1  outline-only request (see Configuration)
- fb_ready  in  1  controller ready; a write is accepted on any edge where wr_valid && fb_ready
- wr_valid  out  1  Waddr/Wdata hold a pixel to write
- Waddr  out  ADDR_W  linear address, y*H_RES + x
- Wdata  out  3  color index
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, CLIP, DRAW, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields and go to CLIP. Inputs are ignored outside IDLE.
- CLIP: one cycle.
  - x1 = min(cmd_x+cmd_w, H_RES), computed at 11 bits.
  - y1 = min(cmd_y+cmd_h, V_RES), computed at 10 bits.
  - Empty rectangle: cmd_w==0, cmd_h==0, cmd_x>=H_RES or cmd_y>=V_RES. Go to DONE with no writes.
  - Otherwise: row_base = cmd_y*H_RES, computed by shift-add (y*512 + y*128) with no multiplier. Waddr = row_base + cmd_x. Go to DRAW.
- DRAW:
  - wr_valid=1. Waddr/Wdata advance only on an accepted write; when fb_ready=0 they hold stable.
  - Within a row, x increments and Waddr increments by 1.
  - At x==x1-1: row_base += H_RES, x = cmd_x, Waddr = new row_base + cmd_x, y increments.
  - An accepted write at (x1-1, y1-1) goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address never exceeds H_RES*V_RES-1. Clipping guarantees this; there is no wrap-around.
- busy = (state != IDLE).
- Reset (also mid-command): state IDLE and the current command is abandoned. Outputs: cmd_ready=1, wr_valid=0, done=0, busy=0, Waddr=0, Wdata=0. No partial write is retracted.

## Timing
- Acceptance edge to first wr_valid: 2 cycles (latch, CLIP).
- Throughput: 1 pixel/cycle while fb_ready is held high.
- Fill of N clipped pixels with fb_ready always high: acceptance to done pulse = N+2 cycles.
- done to next cmd_ready: cmd_ready rises the cycle after done. Back-to-back commands therefore cost a 2-cycle gap (DONE, IDLE).
- Empty command: done asserts 2 cycles after acceptance.
- fb_ready may toggle on any cycle. The engine never drops a pixel and never emits one twice.

## Configuration
- RECT_OUTLINE_EN defined:
  - cmd_outline=1 writes only the border pixels: the full first and last rows, plus columns cmd_x and x1-1 on interior rows.
  - On an interior row, after the write at cmd_x, Waddr jumps to row_base+x1-1 in one step.
  - Widths of 1 or 2 degenerate to a fill.
  - Outline N = 2*w + 2*(h-2) for w,h >= 2 after clipping.
- RECT_OUTLINE_EN not defined: cmd_outline is ignored and every command is a solid fill. The outline logic is absent.

## Test plan
- Reset, then fill x=0,y=0,w=2,h=2,color=3, fb_ready=1 -> writes at addresses 0,1,640,641 with Wdata=3; done 6 cycles after acceptance.
- Fill x=630,y=470,w=20,h=20 -> clipped to 10x10. Last Waddr is 307199, 100 writes in total, no address >= 307200.
- Same 2x2 fill with fb_ready toggled 1,0,0,1,0,1 -> Waddr/Wdata held during stalls, still exactly 4 writes in order 0,1,640,641.
- w=0 or x=700 -> zero wr_valid cycles; done 2 cycles after acceptance; cmd_ready returns.
- Assert rst during the 3rd pixel of a 4x4 fill -> all outputs at reset values the same cycle; a new command is accepted immediately after.
- RECT_OUTLINE_EN defined, outline x=10,y=10,w=4,h=4 -> 12 writes; row 11 writes only addresses 7050 and 7053.
